// File: rtl/lcd_bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_bus_sequencer_if
// Client write handshake between a character/command source and the LCD bus
// sequencer.
//   WrReq   client -> seq  write request, level, held until WrAck
//   WrRS    client -> seq  register select for the byte (0 command, 1 data)
//   WrDato  client -> seq  byte to write
//   WrAck   seq -> client  one-cycle pulse, transfer and its wait time done
//   Busy    seq -> client  sequencer is not idle
// ---------------------------------------------------------------------------
interface lcd_bus_sequencer_if;
  logic       WrReq;
  logic       WrRS;
  logic [7:0] WrDato;
  logic       WrAck;
  logic       Busy;

  modport master (
    output WrReq,
    output WrRS,
    output WrDato,
    input  WrAck,
    input  Busy
  );

  modport slave (
    input  WrReq,
    input  WrRS,
    input  WrDato,
    output WrAck,
    output Busy
  );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_bus_sequencer
// Owns the 8-bit HD44780 LCD bus. After power-up it waits, starts the init
// FSM with a Comenzar pulse, then times every init command and returns a
// Cuenta pulse per command. Once DoneInit is high it serves writes from a
// single client over a req/ack handshake.
//
// Ports
//   Clk        in   system clock, all logic on the rising edge
//   Reset      in   synchronous, active-high
//   Init       in   init FSM has a command pending
//   DatoInit   in   init command byte
//   DoneInit   in   init sequence complete
//   Comenzar   out  one-cycle pulse that starts the init FSM
//   Cuenta     out  one-cycle pulse: current init command finished
//   wr         slave side of the client write handshake
//   LCD_E      out  LCD enable strobe
//   LCD_RS     out  LCD register select
//   LCD_RW     out  tied low, the bus is write-only
//   LCD_DB     out  LCD data bus
// ---------------------------------------------------------------------------
module lcd_bus_sequencer #(
  parameter int CNT_W     = 20,
  parameter int PWRUP_CYC = 750000,
  parameter int SETUP_CYC = 2,
  parameter int EHIGH_CYC = 12,
  parameter int CMD_CYC   = 2000,
  parameter int CLR_CYC   = 82000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Init,
  input  logic [7:0]          DatoInit,
  input  logic                DoneInit,
  output logic                Comenzar,
  output logic                Cuenta,
  lcd_bus_sequencer_if.slave  wr,
  output logic                LCD_E,
  output logic                LCD_RS,
  output logic                LCD_RW,
  output logic [7:0]          LCD_DB
);

  // Every timed state loads CYC-1 on entry and leaves when the counter is 0,
  // so it lasts exactly CYC cycles.
  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(EHIGH_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    START = 3'd1,
    IDLE  = 3'd2,
    SETUP = 3'd3,
    EHIGH = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6,
    GAP   = 3'd7
  } state_t;

  typedef enum logic {
    OWN_INIT   = 1'b0,
    OWN_CLIENT = 1'b1
  } owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] counter;
  // Reset leaves the counter at 0, so the first power-up cycle only loads it.
  logic             pwrup_armed;

  // Clear (0x01) and Return Home (0x02/0x03) need the long execution time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] db);
    return (rs == 1'b0) && (db[7:2] == 6'd0) && (db[1:0] != 2'd0);
  endfunction

  assign LCD_RW = 1'b0;

  // Bus sequencing FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= PWRUP;
      owner       <= OWN_INIT;
      counter     <= CNT_ZERO;
      pwrup_armed <= 1'b0;
      Comenzar    <= 1'b0;
      Cuenta      <= 1'b0;
      wr.WrAck    <= 1'b0;
      wr.Busy     <= 1'b1;
      LCD_E       <= 1'b0;
      LCD_RS      <= 1'b0;
      LCD_DB      <= 8'h00;
    end else begin
      // Pulses are high only in the cycle right after they are set.
      Comenzar <= 1'b0;
      Cuenta   <= 1'b0;
      wr.WrAck <= 1'b0;

      case (state)
        PWRUP: begin
          if (!pwrup_armed) begin
            counter     <= PWRUP_LD;
            pwrup_armed <= 1'b1;
          end else if (counter == CNT_ZERO) begin
            state    <= START;
            Comenzar <= 1'b1;
          end else begin
            counter <= counter - CNT_ONE;
          end
        end

        START: begin
          state <= GAP;
        end

        IDLE: begin
          // Init has priority; a client request before DoneInit just waits.
          if (Init && !DoneInit) begin
            owner   <= OWN_INIT;
            LCD_RS  <= 1'b0;
            LCD_DB  <= DatoInit;
            counter <= SETUP_LD;
            wr.Busy <= 1'b1;
            state   <= SETUP;
          end else if (DoneInit && wr.WrReq) begin
            owner   <= OWN_CLIENT;
            LCD_RS  <= wr.WrRS;
            LCD_DB  <= wr.WrDato;
            counter <= SETUP_LD;
            wr.Busy <= 1'b1;
            state   <= SETUP;
          end else begin
            state <= IDLE;
          end
        end

        SETUP: begin
          if (counter == CNT_ZERO) begin
            LCD_E   <= 1'b1;
            counter <= EHIGH_LD;
            state   <= EHIGH;
          end else begin
            counter <= counter - CNT_ONE;
          end
        end

        EHIGH: begin
          if (counter == CNT_ZERO) begin
            LCD_E   <= 1'b0;
            counter <= is_slow_cmd(LCD_RS, LCD_DB) ? CLR_LD : CMD_LD;
            state   <= WAIT;
          end else begin
            counter <= counter - CNT_ONE;
          end
        end

        WAIT: begin
          if (counter == CNT_ZERO) begin
            if (owner == OWN_CLIENT) begin
              wr.WrAck <= 1'b1;
            end else begin
              Cuenta <= 1'b1;
            end
            state <= DONE;
          end else begin
            counter <= counter - CNT_ONE;
          end
        end

        DONE: begin
          state <= GAP;
        end

        // One spare cycle so the init FSM has moved on before the next grant.
        GAP: begin
          wr.Busy <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state       <= PWRUP;
          counter     <= CNT_ZERO;
          pwrup_armed <= 1'b0;
          LCD_E       <= 1'b0;
          wr.Busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_sequencer
// Directed bench for lcd_bus_sequencer with shortened timing parameters.
// Expected cycle counts below are worked out by hand for these parameters:
//   transfer wait seen at Cuenta/WrAck (E low age) = WAIT + 1 -> 21 or 61
//   Cuenta-to-Cuenta spacing = wait of the later byte + 17 -> 37 or 77
//   E-rise-to-E-rise spacing = wait of the earlier byte + 17 -> 37 or 77
// ---------------------------------------------------------------------------
module tb_lcd_bus_sequencer;

  localparam int P   = 40;
  localparam int SU  = 2;
  localparam int EH  = 12;
  localparam int CMD = 20;
  localparam int CLR = 60;

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b1;
  logic       Init     = 1'b0;
  logic       DoneInit = 1'b0;
  logic [7:0] DatoInit = 8'h00;
  logic       Comenzar;
  logic       Cuenta;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DB;

  lcd_bus_sequencer_if wr();

  lcd_bus_sequencer #(
    .CNT_W(20), .PWRUP_CYC(P), .SETUP_CYC(SU), .EHIGH_CYC(EH),
    .CMD_CYC(CMD), .CLR_CYC(CLR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Init(Init), .DatoInit(DatoInit),
    .DoneInit(DoneInit), .Comenzar(Comenzar), .Cuenta(Cuenta), .wr(wr),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DB(LCD_DB)
  );

  always #5 Clk = ~Clk;

  int nchecks = 0;
  int nerrors = 0;

  logic e_prev    = 1'b0;
  logic e_cur     = 1'b0;
  int   busy_age  = 0;
  int   e_low_age = 0;
  int   cyc_now   = 0;
  bit   model_en  = 1'b0;
  int   idx       = 0;

  logic [7:0] seq [10] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h30,
                           8'h08, 8'h06, 8'h01, 8'h80, 8'h0F};
  int exp_ewait [10] = '{21, 21, 21, 21, 21, 21, 21, 61, 21, 21};
  int exp_cgap  [10] = '{0, 37, 37, 37, 37, 37, 37, 77, 37, 37};
  int exp_egap  [10] = '{0, 37, 37, 37, 37, 37, 37, 37, 77, 37};

  // One clock: sample on the falling edge, then let the init model react.
  task automatic tick();
    e_prev = e_cur;
    @(posedge Clk);
    @(negedge Clk);
    cyc_now++;
    e_cur = LCD_E;
    if (wr.Busy) busy_age++; else busy_age = 0;
    if (!LCD_E) e_low_age++; else e_low_age = 0;
    if (model_en) begin
      if (Comenzar) begin
        idx = 0;
        Init = 1'b1;
        DatoInit = seq[0];
      end else if (Cuenta && Init) begin
        idx++;
        if (idx < 10) DatoInit = seq[idx];
        else begin
          Init = 1'b0;
          DoneInit = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    nchecks++; if (Comenzar !== 1'b0) begin nerrors++; $display("FAIL rst_comenzar: got %b want 0", Comenzar); end
    nchecks++; if (Cuenta !== 1'b0) begin nerrors++; $display("FAIL rst_cuenta: got %b want 0", Cuenta); end
    nchecks++; if (wr.WrAck !== 1'b0) begin nerrors++; $display("FAIL rst_wrack: got %b want 0", wr.WrAck); end
    nchecks++; if (wr.Busy !== 1'b1) begin nerrors++; $display("FAIL rst_busy: got %b want 1", wr.Busy); end
    nchecks++; if (LCD_E !== 1'b0) begin nerrors++; $display("FAIL rst_e: got %b want 0", LCD_E); end
    nchecks++; if (LCD_RS !== 1'b0) begin nerrors++; $display("FAIL rst_rs: got %b want 0", LCD_RS); end
    nchecks++; if (LCD_RW !== 1'b0) begin nerrors++; $display("FAIL rst_rw: got %b want 0", LCD_RW); end
    nchecks++; if (LCD_DB !== 8'h00) begin nerrors++; $display("FAIL rst_db: got %h want 00", LCD_DB); end
  endtask

  // Releases Reset and expects Comenzar on the (P+1)th rising edge.
  task automatic test_powerup(input string tag);
    int found = 0;
    int bad_e = 0;
    int stray = 0;
    Reset = 1'b0;
    for (int k = 1; k <= P + 20 && found == 0; k++) begin
      tick();
      if (Comenzar) found = k;
      else if (LCD_E) bad_e++;
      if (Cuenta || wr.WrAck) stray++;
    end
    nchecks++; if (found !== P + 1) begin nerrors++; $display("FAIL %s_delay: got %0d want %0d", tag, found, P + 1); end
    nchecks++; if (bad_e !== 0) begin nerrors++; $display("FAIL %s_e_early: got %0d want 0", tag, bad_e); end
    nchecks++; if (stray !== 0) begin nerrors++; $display("FAIL %s_stray_pulse: got %0d want 0", tag, stray); end
    tick();
    nchecks++; if (Comenzar !== 1'b0) begin nerrors++; $display("FAIL %s_one_pulse: got %b want 0", tag, Comenzar); end
  endtask

  task automatic test_init();
    int n_pulse = 0, n_cuenta = 0, width = 0, acks = 0;
    int last_c = 0, last_r = 0;
    for (int c = 0; c < 3000 && !DoneInit; c++) begin
      tick();
      if (e_cur && !e_prev) begin
        nchecks++; if (busy_age !== SU + 1) begin nerrors++; $display("FAIL init_setup[%0d]: got %0d want %0d", n_pulse, busy_age, SU + 1); end
        nchecks++; if (LCD_RS !== 1'b0) begin nerrors++; $display("FAIL init_rs[%0d]: got %b want 0", n_pulse, LCD_RS); end
        if (n_pulse < 10) begin
          nchecks++; if (LCD_DB !== seq[n_pulse]) begin nerrors++; $display("FAIL init_db[%0d]: got %h want %h", n_pulse, LCD_DB, seq[n_pulse]); end
          if (n_pulse > 0) begin
            nchecks++; if (cyc_now - last_r !== exp_egap[n_pulse]) begin nerrors++; $display("FAIL init_egap[%0d]: got %0d want %0d", n_pulse, cyc_now - last_r, exp_egap[n_pulse]); end
          end
        end
        last_r = cyc_now;
        width = 0;
      end
      if (e_cur) width++;
      if (!e_cur && e_prev) begin
        nchecks++; if (width !== EH) begin nerrors++; $display("FAIL init_width[%0d]: got %0d want %0d", n_pulse, width, EH); end
        n_pulse++;
      end
      if (wr.WrAck) acks++;
      if (Cuenta) begin
        if (n_cuenta < 10) begin
          nchecks++; if (e_low_age !== exp_ewait[n_cuenta]) begin nerrors++; $display("FAIL init_wait[%0d]: got %0d want %0d", n_cuenta, e_low_age, exp_ewait[n_cuenta]); end
          if (n_cuenta > 0) begin
            nchecks++; if (cyc_now - last_c !== exp_cgap[n_cuenta]) begin nerrors++; $display("FAIL init_cgap[%0d]: got %0d want %0d", n_cuenta, cyc_now - last_c, exp_cgap[n_cuenta]); end
          end
        end
        last_c = cyc_now;
        n_cuenta++;
      end
    end
    nchecks++; if (DoneInit !== 1'b1) begin nerrors++; $display("FAIL init_timeout: DoneInit got %b want 1", DoneInit); end
    nchecks++; if (n_pulse !== 10) begin nerrors++; $display("FAIL init_pulses: got %0d want 10", n_pulse); end
    nchecks++; if (n_cuenta !== 10) begin nerrors++; $display("FAIL init_cuentas: got %0d want 10", n_cuenta); end
    nchecks++; if (acks !== 0) begin nerrors++; $display("FAIL init_early_ack: got %0d want 0", acks); end
  endtask

  // One client write; exp_age is the wait length plus the DONE cycle.
  task automatic test_client(input string tag, input logic rs, input logic [7:0] dato, input int exp_age);
    bit got = 1'b0;
    wr.WrRS = rs;
    wr.WrDato = dato;
    wr.WrReq = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      tick();
      if (e_cur && !e_prev) begin
        nchecks++; if (LCD_RS !== rs) begin nerrors++; $display("FAIL %s_rs: got %b want %b", tag, LCD_RS, rs); end
        nchecks++; if (LCD_DB !== dato) begin nerrors++; $display("FAIL %s_db: got %h want %h", tag, LCD_DB, dato); end
        wr.WrDato = ~dato;
        wr.WrRS = ~rs;
      end
      if (!e_cur && e_prev) begin
        nchecks++; if (LCD_DB !== dato || LCD_RS !== rs) begin nerrors++; $display("FAIL %s_hold: got %b/%h want %b/%h", tag, LCD_RS, LCD_DB, rs, dato); end
      end
      if (wr.WrAck) begin
        got = 1'b1;
        nchecks++; if (e_low_age !== exp_age) begin nerrors++; $display("FAIL %s_wait: got %0d want %0d", tag, e_low_age, exp_age); end
        wr.WrReq = 1'b0;
      end
    end
    nchecks++; if (got !== 1'b1) begin nerrors++; $display("FAIL %s_timeout: ack got %b want 1", tag, got); end
    tick();
    nchecks++; if (wr.WrAck !== 1'b0 || wr.Busy !== 1'b1) begin nerrors++; $display("FAIL %s_gap: ack/busy got %b/%b want 0/1", tag, wr.WrAck, wr.Busy); end
    tick();
    nchecks++; if (wr.Busy !== 1'b0 || LCD_DB !== dato) begin nerrors++; $display("FAIL %s_idle: busy/db got %b/%h want 0/%h", tag, wr.Busy, LCD_DB, dato); end
  endtask

  task automatic test_reset_mid();
    bit rose = 1'b0;
    wr.WrRS = 1'b1;
    wr.WrDato = 8'h42;
    wr.WrReq = 1'b1;
    for (int c = 0; c < 50 && !rose; c++) begin
      tick();
      if (e_cur && !e_prev) rose = 1'b1;
    end
    nchecks++; if (rose !== 1'b1) begin nerrors++; $display("FAIL mid_e_rise: got %b want 1", rose); end
    tick();
    tick();
    Reset = 1'b1;
    model_en = 1'b0;
    Init = 1'b0;
    DoneInit = 1'b0;
    wr.WrReq = 1'b0;
    tick();
    nchecks++; if (LCD_E !== 1'b0) begin nerrors++; $display("FAIL mid_e_drop: got %b want 0", LCD_E); end
    nchecks++; if (Cuenta !== 1'b0 || wr.WrAck !== 1'b0) begin nerrors++; $display("FAIL mid_pulses: cuenta/ack got %b/%b want 0/0", Cuenta, wr.WrAck); end
    nchecks++; if (wr.Busy !== 1'b1 || LCD_DB !== 8'h00) begin nerrors++; $display("FAIL mid_state: busy/db got %b/%h want 1/00", wr.Busy, LCD_DB); end
    test_powerup("mid_pwrup");
  endtask

  task automatic test_collision();
    int pulses = 0, rs1 = 0, cu = 0, acks = 0;
    Init = 1'b1;
    DatoInit = 8'h38;
    wr.WrRS = 1'b1;
    wr.WrDato = 8'h55;
    wr.WrReq = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (e_cur && !e_prev) begin
        pulses++;
        if (LCD_RS) rs1++;
        nchecks++; if (LCD_DB !== 8'h38) begin nerrors++; $display("FAIL coll_db: got %h want 38", LCD_DB); end
      end
      if (Cuenta) begin
        cu++;
        Init = 1'b0;
      end
      if (wr.WrAck) acks++;
    end
    nchecks++; if (pulses !== 1 || rs1 !== 0) begin nerrors++; $display("FAIL coll_pulses: got %0d (rs1 %0d) want 1 (0)", pulses, rs1); end
    nchecks++; if (cu !== 1) begin nerrors++; $display("FAIL coll_cuenta: got %0d want 1", cu); end
    nchecks++; if (acks !== 0) begin nerrors++; $display("FAIL coll_ack: got %0d want 0", acks); end
    DoneInit = 1'b1;
    test_client("coll_late", 1'b1, 8'h55, CMD + 1);
  endtask

  initial begin
    wr.WrReq = 1'b0;
    wr.WrRS = 1'b0;
    wr.WrDato = 8'h00;
    test_reset();
    model_en = 1'b1;
    wr.WrRS = 1'b1;
    wr.WrDato = 8'h41;
    wr.WrReq = 1'b1;
    test_powerup("pwrup");
    test_init();
    test_client("pend_41", 1'b1, 8'h41, CMD + 1);
    test_client("clr_rs0", 1'b0, 8'h01, CLR + 1);
    test_client("clr_rs1", 1'b1, 8'h01, CMD + 1);
    test_client("home_rs0", 1'b0, 8'h03, CLR + 1);
    test_client("byte04", 1'b0, 8'h04, CMD + 1);
    test_reset_mid();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
